// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control unit: exception codes,
// stall-mask bit positions and the control FSM state type.
package pipe_pkg;

    // Exception codes presented on exctype by the MEM stage.
    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL    = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES    = 32'h0000_0005;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_BREAK   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI      = 32'h0000_000A;
    localparam logic [31:0] EXC_OV      = 32'h0000_000C;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000D;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000E;

    // Bit of the stall mask that freezes the PC register.
    localparam int unsigned STALL_PC = 0;

    // Legacy state encodings kept so existing debug tooling still decodes them.
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    typedef enum logic [0:0] {
        RUN   = ST_RUN,
        FLUSH = ST_FLUSH
    } pipe_state_t;

    // ERET returns to EPC; every other exception goes to the fixed vector.
    function automatic logic is_eret(input logic [31:0] code);
        return code == EXC_ERET;
    endfunction

endpackage

// File: rtl/stall_mask_gen.sv
// Combinational stall-mask generator: the highest stage requesting a stall
// freezes itself and every earlier stage plus the PC register.
module stall_mask_gen
    import pipe_pkg::*;
#(
    parameter int unsigned NSTAGE = 5
) (
    input  logic [NSTAGE-1:0] stallreq,
    output logic [NSTAGE:0]   mask
);

    logic acc;

    // Sweep from the last stage toward IF, OR-accumulating requests into a thermometer.
    always_comb begin
        mask = '0;
        acc  = 1'b0;
        for (int unsigned i = 0; i < NSTAGE; i++) begin
            acc = acc | stallreq[NSTAGE-1-i];
            mask[NSTAGE-i] = acc;
        end
        mask[STALL_PC] = acc;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: stall mask, exception flush window with redirect PC,
// saturating stall-cycle counter and optional stall watchdog.
// Optional feature: define PIPE_CTRL_WDOG_EN to build the stall watchdog.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned NSTAGE       = 5,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned WDOG_LIMIT   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq,
    output logic [NSTAGE:0]   stall,
    input  logic [31:0]       exctype,
    input  logic [31:0]       cp0_epc,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              busy,
    input  logic              stall_cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              wdog_trip
);

    // fcnt only has to hold FLUSH_CYCLES-2; keep at least one bit.
    localparam int unsigned FW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;

    // FLUSH_CYCLES and WDOG_LIMIT must both be at least 1; no hardware otherwise.
    if (FLUSH_CYCLES < 1 || WDOG_LIMIT < 1) begin : g_illegal_cfg
    end

    pipe_state_t       state;
    logic [FW-1:0]     fcnt;
    logic [31:0]       redir_q;
    logic [31:0]       exc_target;
    logic [NSTAGE:0]   mask;
    logic              exc_take;
    logic              flush_int;
    logic              stalled;
    logic [CNT_W-1:0]  cnt_q;

    stall_mask_gen #(
        .NSTAGE (NSTAGE)
    ) u_mask (
        .stallreq (stallreq),
        .mask     (mask)
    );

    // Exception acceptance and redirect target; exctype is ignored inside a flush window.
    always_comb begin
        exc_take   = (state == RUN) && (exctype != EXC_NONE);
        exc_target = is_eret(exctype) ? cp0_epc : EXC_VECTOR;
        flush_int  = (state == FLUSH) || exc_take;
    end

    // Output drive; reset gates every combinational output, flush overrides stalls.
    always_comb begin
        flush     = !rst && flush_int;
        busy      = !rst && (state == FLUSH);
        new_pc    = '0;
        if (!rst) begin
            if (state == FLUSH) begin
                new_pc = redir_q;
            end else if (exc_take) begin
                new_pc = exc_target;
            end
        end
        stall     = (rst || flush_int) ? '0 : mask;
        stalled   = |stall;
        stall_cnt = rst ? '0 : cnt_q;
    end

    // Flush window sequencing: first cycle is spent in RUN, the remaining FLUSH_CYCLES-1 in FLUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            fcnt    <= '0;
            redir_q <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (exc_take) begin
                        redir_q <= exc_target;
                        if (FLUSH_CYCLES > 1) begin
                            state <= FLUSH;
                            fcnt  <= FW'(FLUSH_CYCLES - 2);
                        end
                    end
                end
                FLUSH: begin
                    if (fcnt == '0) begin
                        state <= RUN;
                    end else begin
                        fcnt <= fcnt - FW'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Saturating count of stalled cycles; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (stall_cnt_clr) begin
            cnt_q <= '0;
        end else if (stalled && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef PIPE_CTRL_WDOG_EN
    localparam int unsigned WDW = $clog2(WDOG_LIMIT + 1);

    logic [WDW-1:0] wdcnt;
    logic [WDW-1:0] wd_next;
    logic           trip_q;

    // Run length of consecutive stalled cycles including the current one, saturating at the limit.
    always_comb begin
        wd_next = '0;
        if (stalled) begin
            wd_next = (wdcnt == WDW'(WDOG_LIMIT)) ? wdcnt : wdcnt + WDW'(1);
        end
    end

    // Watchdog state; the trip flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdcnt  <= '0;
            trip_q <= 1'b0;
        end else begin
            wdcnt <= wd_next;
            if (wd_next == WDW'(WDOG_LIMIT)) begin
                trip_q <= 1'b1;
            end
        end
    end

    assign wdog_trip = !rst && trip_q;
`else
    assign wdog_trip = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl. Instance u0 (FLUSH_CYCLES=3,
// CNT_W=4, WDOG_LIMIT=8) covers masking, flush windows, counting and the
// watchdog; u1 (FLUSH_CYCLES=4) and u2 (FLUSH_CYCLES=1) share inputs and
// cover reset mid-flush and the single-cycle window.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_WDOG_EN
    localparam logic WD_EN = 1'b1;
`else
    localparam logic WD_EN = 1'b0;
`endif

    localparam logic [31:0] VEC  = 32'hBFC0_0380;
    localparam logic [31:0] ERET = 32'h0000_000E;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // u0 signals
    logic        a_rst, a_clr, a_flush, a_busy, a_trip;
    logic [4:0]  a_stallreq;
    logic [5:0]  a_stall;
    logic [31:0] a_exctype, a_epc, a_new_pc;
    logic [3:0]  a_cnt;

    // u1/u2 shared inputs
    logic        b_rst, b_clr, b_flush, b_busy, b_trip;
    logic [4:0]  b_stallreq;
    logic [5:0]  b_stall;
    logic [31:0] b_exctype, b_epc, b_new_pc, b_cnt;
    logic        c_flush, c_busy, c_trip;
    logic [5:0]  c_stall;
    logic [31:0] c_new_pc, c_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_ctrl #(.NSTAGE(5), .FLUSH_CYCLES(3), .EXC_VECTOR(VEC), .CNT_W(4), .WDOG_LIMIT(8)) u0 (
        .clk(clk), .rst(a_rst), .stallreq(a_stallreq), .stall(a_stall),
        .exctype(a_exctype), .cp0_epc(a_epc), .flush(a_flush), .new_pc(a_new_pc),
        .busy(a_busy), .stall_cnt_clr(a_clr), .stall_cnt(a_cnt), .wdog_trip(a_trip));

    pipe_ctrl #(.NSTAGE(5), .FLUSH_CYCLES(4), .EXC_VECTOR(VEC), .CNT_W(32), .WDOG_LIMIT(1024)) u1 (
        .clk(clk), .rst(b_rst), .stallreq(b_stallreq), .stall(b_stall),
        .exctype(b_exctype), .cp0_epc(b_epc), .flush(b_flush), .new_pc(b_new_pc),
        .busy(b_busy), .stall_cnt_clr(b_clr), .stall_cnt(b_cnt), .wdog_trip(b_trip));

    pipe_ctrl #(.NSTAGE(5), .FLUSH_CYCLES(1), .EXC_VECTOR(VEC), .CNT_W(32), .WDOG_LIMIT(1024)) u2 (
        .clk(clk), .rst(b_rst), .stallreq(b_stallreq), .stall(c_stall),
        .exctype(b_exctype), .cp0_epc(b_epc), .flush(c_flush), .new_pc(c_new_pc),
        .busy(c_busy), .stall_cnt_clr(b_clr), .stall_cnt(c_cnt), .wdog_trip(c_trip));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst = 1'b1; a_clr = 1'b0; a_stallreq = 5'b11111; a_exctype = 32'h1; a_epc = '0;
        b_rst = 1'b1; b_clr = 1'b0; b_stallreq = '0;      b_exctype = '0;    b_epc = '0;
        #1;
        // reset gating of combinational outputs
        chk("rst_stall",  a_stall,  0);
        chk("rst_flush",  a_flush,  0);
        chk("rst_new_pc", a_new_pc, 0);
        chk("rst_busy",   a_busy,   0);
        adv(); adv();
        chk("rst_cnt",    a_cnt,    0);
        chk("rst_trip",   a_trip,   0);
        a_rst = 1'b0; b_rst = 1'b0; a_exctype = '0; a_stallreq = 5'b00100;
        #1;
        // stall mask: k=2 -> bits 0..3
        chk("mask_00100", a_stall, 6'b001111);
        adv(); a_stallreq = 5'b10001; #1;
        chk("mask_10001", a_stall, 6'b111111);
        adv(); a_stallreq = 5'b00001; #1;
        chk("mask_00001", a_stall, 6'b000011);
        adv(); a_stallreq = 5'b00000; a_clr = 1'b1; #1;
        chk("mask_zero",  a_stall, 6'b000000);
        chk("cnt_3",      a_cnt,   4'd3);
        adv(); a_clr = 1'b0;
        chk("cnt_clr",    a_cnt,   4'd0);

        // exception with all stages stalling
        a_stallreq = 5'b11111; a_exctype = 32'h1; #1;
        chk("exc_flush",  a_flush,  1);
        chk("exc_pc",     a_new_pc, VEC);
        chk("exc_stall",  a_stall,  0);
        chk("exc_busy1",  a_busy,   0);
        adv(); a_exctype = '0; #1;
        chk("exc_c2_flush", a_flush,  1);
        chk("exc_c2_busy",  a_busy,   1);
        chk("exc_c2_pc",    a_new_pc, VEC);
        chk("exc_c2_stall", a_stall,  0);
        adv();
        chk("exc_c3_flush", a_flush,  1);
        chk("exc_c3_busy",  a_busy,   1);
        adv();
        chk("exc_c4_flush", a_flush,  0);
        chk("exc_c4_busy",  a_busy,   0);
        chk("exc_c4_pc",    a_new_pc, 0);
        chk("exc_c4_stall", a_stall,  6'b111111);
        chk("exc_c4_cnt",   a_cnt,    0);
        adv(); a_stallreq = '0; #1;
        chk("exc_cnt_1",    a_cnt,    1);

        // ERET window; second exception inside the window is ignored
        a_exctype = ERET; a_epc = 32'h8000_1234; #1;
        chk("eret_c1_flush", a_flush,  1);
        chk("eret_c1_pc",    a_new_pc, 32'h8000_1234);
        chk("eret_c1_busy",  a_busy,   0);
        adv(); a_exctype = 32'h1; a_epc = 32'hDEAD_BEEF; #1;
        chk("eret_c2_flush", a_flush,  1);
        chk("eret_c2_pc",    a_new_pc, 32'h8000_1234);
        chk("eret_c2_busy",  a_busy,   1);
        adv(); a_exctype = '0; #1;
        chk("eret_c3_flush", a_flush,  1);
        chk("eret_c3_pc",    a_new_pc, 32'h8000_1234);
        chk("eret_c3_busy",  a_busy,   1);
        // back-to-back exception on the first RUN cycle
        adv(); a_exctype = 32'h1; #1;
        chk("b2b_c1_flush", a_flush,  1);
        chk("b2b_c1_busy",  a_busy,   0);
        chk("b2b_c1_pc",    a_new_pc, VEC);
        adv(); a_exctype = '0; #1;
        chk("b2b_c2_busy",  a_busy,   1);
        chk("b2b_c2_pc",    a_new_pc, VEC);
        adv();
        chk("b2b_c3_flush", a_flush,  1);
        adv();
        chk("b2b_c4_flush", a_flush,  0);
        chk("b2b_c4_pc",    a_new_pc, 0);

        // watchdog: 7 stalled + 1 free + 7 stalled never trips
        a_stallreq = 5'b00001;
        for (int i = 0; i < 7; i++) adv();
        a_stallreq = '0; adv();
        a_stallreq = 5'b00001;
        for (int i = 0; i < 7; i++) adv();
        chk("wd_7_1_7", a_trip, 0);
        a_stallreq = '0; adv();
        a_stallreq = 5'b00001;
        for (int i = 0; i < 7; i++) adv();
        chk("wd_7", a_trip, 0);
        adv();
        chk("wd_8", a_trip, WD_EN);
        a_stallreq = '0; adv(); adv();
        chk("wd_sticky", a_trip, WD_EN);
        a_rst = 1'b1; #1;
        chk("wd_rst_gate", a_trip, 0);
        adv(); a_rst = 1'b0; #1;
        chk("wd_rst_trip", a_trip, 0);
        chk("wd_rst_cnt",  a_cnt,  0);

        // counter clear on the 10th stalled cycle, then saturation at CNT_W=4
        a_stallreq = 5'b00001;
        for (int i = 0; i < 9; i++) adv();
        chk("cnt_9", a_cnt, 4'd9);
        a_clr = 1'b1; adv(); a_clr = 1'b0; #1;
        chk("cnt_clr_prio", a_cnt, 4'd0);
        for (int i = 0; i < 14; i++) adv();
        chk("cnt_14", a_cnt, 4'hE);
        for (int i = 0; i < 6; i++) adv();
        chk("cnt_sat", a_cnt, 4'hF);
        a_stallreq = '0;

        // u1 (4-cycle window) and u2 (1-cycle window)
        b_stallreq = 5'b00010; #1;
        chk("b_mask", b_stall, 6'b000111);
        adv(); b_exctype = 32'h9; #1;
        chk("b_cnt_1",   b_cnt,    1);
        chk("b_flush",   b_flush,  1);
        chk("c_flush",   c_flush,  1);
        chk("c_pc",      c_new_pc, VEC);
        chk("c_stall",   c_stall,  0);
        adv(); b_exctype = '0; #1;
        chk("c_done_flush", c_flush, 0);
        chk("c_done_busy",  c_busy,  0);
        chk("c_done_stall", c_stall, 6'b000111);
        chk("b_c2_busy",    b_busy,  1);
        chk("b_c2_flush",   b_flush, 1);
        // reset during flush cycle 2 of 4
        b_rst = 1'b1; #1;
        chk("b_rst_flush", b_flush,  0);
        chk("b_rst_busy",  b_busy,   0);
        chk("b_rst_pc",    b_new_pc, 0);
        chk("b_rst_cnt",   b_cnt,    0);
        adv(); b_rst = 1'b0; b_stallreq = '0; #1;
        chk("b_post_flush", b_flush,  0);
        chk("b_post_busy",  b_busy,   0);
        chk("b_post_cnt",   b_cnt,    0);
        chk("b_post_pc",    b_new_pc, 0);
        adv();
        chk("b_post2_flush", b_flush, 0);
        chk("b_trip",        b_trip,  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
